// File: rtl/seq_det_ctrl_if.sv
// Handshake/data bundle between the sequencing controller and its environment.
// Carries the word request, the serial detector link and the per-word results.
// Widths track the controller parameters; both ends must use the same values.
interface seq_det_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             det_in;
    logic             ser_out;
    logic             det_rst;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] det_count;
    logic [WIDTH-1:0] det_pos;

    // Environment side: requests words and returns the detector output.
    modport master (
        output start, data_in, det_in,
        input  ser_out, det_rst, busy, done, det_count, det_pos
    );

    // Controller side.
    modport slave (
        input  start, data_in, det_in,
        output ser_out, det_rst, busy, done, det_count, det_pos
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Serialises a word MSB-first into a Mealy sequence detector and tallies its hits per bit.
// Latency: start edge to done pulse is WIDTH+1 cycles; one word per WIDTH+2 cycles.
// No backpressure: start is taken only in IDLE (and at idx=0 when SEQ_DET_CTRL_CONT_EN is defined).
module seq_det_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_det_ctrl_if.slave      bus
);
    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] acc_cnt, cnt_nxt;
    logic [WIDTH-1:0] acc_pos, pos_nxt;
    logic [CNT_W-1:0] det_count_q;
    logic [WIDTH-1:0] det_pos_q;
    logic             done_q;
    logic             load;
    logic             publish;
    logic             last;

    assign last = (idx == '0);

    // The detector is only released while a bit is actually on the wire.
    assign bus.ser_out   = (state == SHIFT) ? shreg[idx] : 1'b0;
    assign bus.det_rst   = (state != SHIFT);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.det_count = det_count_q;
    assign bus.det_pos   = det_pos_q;

    // Accumulator update for the bit currently on ser_out; counter saturates at all-ones.
    always_comb begin
        cnt_nxt = acc_cnt;
        pos_nxt = acc_pos;
        if (state == SHIFT && bus.det_in) begin
            pos_nxt[idx] = 1'b1;
            if (acc_cnt != '1) begin
                cnt_nxt = acc_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state decode: load a new word, finish one, or both at a streaming boundary.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        publish   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (last) begin
                    publish = 1'b1;
`ifdef SEQ_DET_CTRL_CONT_EN
                    if (bus.start) begin
                        state_nxt = SHIFT;
                        load      = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, shift/accumulate datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            acc_cnt     <= '0;
            acc_pos     <= '0;
            det_count_q <= '0;
            det_pos_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= publish;
            if (publish) begin
                det_count_q <= cnt_nxt;
                det_pos_q   <= pos_nxt;
            end
            if (load) begin
                shreg   <= bus.data_in;
                idx     <= IDX_W'(WIDTH - 1);
                acc_cnt <= '0;
                acc_pos <= '0;
            end else if (state == SHIFT) begin
                acc_cnt <= cnt_nxt;
                acc_pos <= pos_nxt;
                if (!last) begin
                    idx <= idx - IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Sequencing controller for the single-bit Mealy sequence detector (ports in/clk/rst/out).
- Accepts a parallel word on a start pulse, resets the detector, and shifts the word into it MSB-first, one bit per clock.
- Samples the detector's Mealy output on every shifted bit and reports a per-word detection count and a bit-position map with a done pulse.

Parameters:
- WIDTH, 8, bits per word shifted into the detector (min 2).
- CNT_W, 4, width of the detection counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to process data_in; sampled only where stated below.
- data_in  input  WIDTH  word to serialise; latched on an accepted start.
- det_in  input  1  detector output (Mealy; combinational in the current serial bit).
- ser_out  output  1  serial bit to detector input.
- det_rst  output  1  detector reset, active-high.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse: results valid.
- det_count  output  CNT_W  detections in the last word (saturating).
- det_pos  output  WIDTH  bit i = 1 if det_in was high while data bit i was on ser_out.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state=IDLE, ser_out=0, det_rst=1, busy=0, done=0, det_count=0, det_pos=0, shift register and bit index 0. Reset mid-word aborts it; results are cleared and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: det_rst=1, ser_out=0.
  - start=1 at edge N latches data_in, clears the accumulators, sets idx=WIDTH-1 and moves to SHIFT.
- SHIFT: det_rst=0, ser_out = shreg[idx], combinationally from the registered shift state.
  - Each cycle, det_in is sampled at the clock edge. If high, acc_pos[idx] is set and acc_cnt is incremented, saturating at all-ones.
  - idx then decrements.
  - SHIFT occupies cycles N+1 .. N+WIDTH. After idx=0, the next state is DONE.
- DONE: det_rst=1, done=1 for exactly one cycle (cycle N+WIDTH+1).
  - det_count/det_pos are loaded from the accumulators on DONE entry, so they are visible in the same cycle as done.
  - Next state is IDLE.
- Outputs det_count/det_pos hold until the next DONE or reset.
- start is ignored in SHIFT and DONE (non-continuous build). A start held high in IDLE is accepted immediately.
- Latency: start edge to done = WIDTH+1 cycles. Back-to-back throughput is one word per WIDTH+2 cycles.
- The detector is held in reset whenever it is not being fed. Every word therefore starts from the detector's reset state, and idle cycles never clock garbage into it.
- Saturation: once det_count reaches 2^CNT_W-1 it stays there. det_pos still records every hit.

Optional Feature:
- Macro SEQ_DET_CTRL_CONT_EN (continuous streaming).
- Defined:
  - start is also sampled in the last SHIFT cycle (idx=0). If high, data_in is latched and the next cycle is SHIFT of the new word with idx=WIDTH-1.
  - det_rst stays 0 across the word boundary, so patterns spanning words are detected and count toward the new word.
  - done pulses during that first new-word SHIFT cycle, carrying the finished word's results. The accumulators are cleared for the new word in that same cycle.
  - Without a start at idx=0, behaviour is as in the non-continuous build.
- Undefined: start is ignored in SHIFT; every word is separated by DONE and IDLE with det_rst=1.

Test Plan:
- The bench drives det_in from a behavioural overlapping 1-0-1 Mealy detector fed by ser_out/det_rst.
- WIDTH=8, start with data_in=8'hAA -> done exactly 9 cycles after the start edge; det_count=3, det_pos=8'h2A; busy high for 9 cycles.
- data_in=8'h00, then 8'hFF -> det_count=0, det_pos=8'h00 for both words. Results from a prior 8'hAA word are replaced only at the new done.
- WIDTH=16, CNT_W=2, data_in=16'hAAAA -> det_count=3 (saturated from 7 hits), det_pos=16'h2AAA.
- start pulsed again during SHIFT; rst asserted at SHIFT cycle 4 -> the extra start is ignored. After rst: outputs 0, det_rst=1, no done, and the next 8'hAA word gives count 3.
- Word 8'h01 then 8'h40, with start high at idx=0:
  - With SEQ_DET_CTRL_CONT_EN: no gap, second word det_pos=8'h40, det_count=1.
  - Without the macro: start is ignored; after IDLE, the second word gives det_pos=8'h00, det_count=0.
